// File: rtl/img_line_server.sv
// Double-buffered 48-line frame store answering single line requests; IMG_LINE_WRAP_EN wraps out-of-range indices.
// Latency: req at edge N, done pulses in the cycle after edge N+2; busy is high for the two cycles in between.
// Backpressure: no queueing, so req is ignored while busy; a swap that arrives mid-request waits for RESP->IDLE.
module img_line_server #(
  parameter int LINE_W    = 6,
  parameter int NUM_LINES = 48,
  parameter int IDX_W     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [LINE_W-1:0] wr_data,
  input  logic              swap,
  input  logic              req,
  input  logic [IDX_W-1:0]  req_line,
  output logic [LINE_W-1:0] line_data,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic              frame_valid
);

  typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

  localparam int unsigned CW = IDX_W + 1;
  localparam logic [CW-1:0] NL = CW'(NUM_LINES);

  state_t state_q, state_d;

  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] data_q;
  logic              oor_q;
  logic              front_q;
  logic              swap_pending_q;
  logic              frame_valid_q;

  logic [LINE_W-1:0] bank0 [NUM_LINES];
  logic [LINE_W-1:0] bank1 [NUM_LINES];

  logic              accept;
  logic              toggle;
  logic              pend_set;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_addr;
  logic              rd_ok;
  logic              wr_ok;
  logic [LINE_W-1:0] rd_word;

  function automatic logic in_range(input logic [IDX_W-1:0] i);
    return {1'b0, i} < NL;
  endfunction

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] i);
    return IDX_W'({1'b0, i} % NL);
  endfunction

`ifdef IMG_LINE_WRAP_EN
  assign rd_idx  = wrap_idx(idx_q);
  assign rd_ok   = 1'b1;
  assign wr_addr = wrap_idx(wr_idx);
  assign wr_ok   = 1'b1;
`else
  assign rd_idx  = idx_q;
  assign rd_ok   = in_range(idx_q);
  assign wr_addr = wr_idx;
  assign wr_ok   = in_range(wr_idx);
`endif

  always_comb begin
    rd_word = '0;
    if (rd_ok) begin
      rd_word = front_q ? bank1[rd_idx] : bank0[rd_idx];
    end
  end

  // A swap is immediate only when no request is in flight or being accepted.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    toggle   = 1'b0;
    pend_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          state_d = FETCH;
        end
        if (swap) begin
          if (req) pend_set = 1'b1;
          else     toggle   = 1'b1;
        end
      end
      FETCH: begin
        state_d  = RESP;
        pend_set = swap;
      end
      RESP: begin
        state_d = IDLE;
        toggle  = swap_pending_q | swap;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      data_q         <= '0;
      oor_q          <= 1'b0;
      line_data      <= '0;
      done           <= 1'b0;
      err            <= 1'b0;
      front_q        <= 1'b0;
      swap_pending_q <= 1'b0;
      frame_valid_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) idx_q <= req_line;
      if (state_q == FETCH) begin
        data_q <= rd_word;
        oor_q  <= ~rd_ok;
      end
      done <= (state_q == RESP);
      err  <= (state_q == RESP) && oor_q;
      if (state_q == RESP) line_data <= data_q;
      if (toggle) begin
        front_q        <= ~front_q;
        frame_valid_q  <= 1'b1;
        swap_pending_q <= 1'b0;
      end else if (pend_set) begin
        swap_pending_q <= 1'b1;
      end
    end
  end

  // Writes always target the pre-toggle back bank, even on the swap edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else if (wr_en && wr_ok) begin
      if (front_q) bank0[wr_addr] <= wr_data;
      else         bank1[wr_addr] <= wr_data;
    end
  end

  assign busy        = (state_q != IDLE);
  assign frame_valid = frame_valid_q;

endmodule
